board_io_cond: RTL and testbench

Parametrised board-level input conditioner and reset sequencer placed between board pins and the sigma SoC in a board top. It generates a sequenced SoC reset from the board reset and the PLL lock. It synchronises and debounces N button and M switch inputs, and produces one-cycle edge pulses for interrupt lines. It replaces direct wiring of raw pins to irq_btn_i, gpio_bi and arst_i.

---
 rtl/board_io_cond.sv | 148 ++++++++++++++
 tb/tb_board_io_cond.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_io_cond.sv
// ============================================================================
// board_io_cond: sequenced SoC reset from board reset and PLL lock, plus
// synchronised and debounced buttons and switches with edge pulses.
// Revision: 1.0
// ============================================================================
`default_nettype none

module board_io_cond #(
   parameter int NUM_BTN         = 1,
   parameter int NUM_SW          = 16,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int RST_HOLD_CYCLES = 16
) (
   input  logic               clk_i,
   input  logic               arst_n_i,
   input  logic               pll_locked_i,
   input  logic [NUM_BTN-1:0] btn_i,
   input  logic [NUM_SW-1:0]  sw_i,
   output logic               soc_rst_o,
   output logic [NUM_BTN-1:0] btn_o,
   output logic [NUM_BTN-1:0] btn_rise_o,
   output logic [NUM_SW-1:0]  sw_o,
   output logic               sw_change_o
);

   localparam int c_NCH = NUM_BTN + NUM_SW;
   localparam int c_DW  = $clog2(DEBOUNCE_CYCLES);
   localparam int c_HW  = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
   localparam logic [c_DW-1:0] c_DEB_MAX  = c_DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [c_HW-1:0] c_HOLD_MAX = c_HW'(RST_HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      S_HOLD  = 2'd0,
      S_COUNT = 2'd1,
      S_RUN   = 2'd2
   } state_t;

   state_t              r_state;
   logic [c_HW-1:0]     r_hold_cnt;
   logic                r_soc_rst;
   logic                r_pll_s1;
   logic                r_pll_s2;
   logic [c_NCH-1:0]    r_in_s1;
   logic [c_NCH-1:0]    r_in_s2;
   logic [c_NCH-1:0]    r_stable_d;
   logic [NUM_BTN-1:0]  r_btn_rise;
   logic                r_sw_change;
   logic [c_NCH-1:0]    w_stable;

   // Buttons occupy the low channels, switches the high channels.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_pll_s1 <= 1'b0;
         r_pll_s2 <= 1'b0;
         r_in_s1  <= '0;
         r_in_s2  <= '0;
      end else begin
         r_pll_s1 <= pll_locked_i;
         r_pll_s2 <= r_pll_s1;
         r_in_s1  <= {sw_i, btn_i};
         r_in_s2  <= r_in_s1;
      end
   end

   // Reset output is registered alongside the state it is derived from.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_state    <= S_HOLD;
         r_hold_cnt <= '0;
         r_soc_rst  <= 1'b1;
      end else if (!r_pll_s2) begin
         r_state    <= S_HOLD;
         r_hold_cnt <= '0;
         r_soc_rst  <= 1'b1;
      end else begin
         case (r_state)
            S_HOLD: begin
               r_state    <= S_COUNT;
               r_hold_cnt <= '0;
               r_soc_rst  <= 1'b1;
            end
            S_COUNT: begin
               if (r_hold_cnt == c_HOLD_MAX) begin
                  r_state    <= S_RUN;
                  r_hold_cnt <= '0;
                  r_soc_rst  <= 1'b0;
               end else begin
                  r_hold_cnt <= r_hold_cnt + 1'b1;
                  r_soc_rst  <= 1'b1;
               end
            end
            S_RUN: begin
               r_soc_rst <= 1'b0;
            end
            default: begin
               r_state    <= S_HOLD;
               r_hold_cnt <= '0;
               r_soc_rst  <= 1'b1;
            end
         endcase
      end
   end

   for (genvar i = 0; i < c_NCH; i++) begin : g_deb
      logic [c_DW-1:0] r_cnt;
      logic            r_stb;

      always_ff @(posedge clk_i or negedge arst_n_i) begin
         if (!arst_n_i) begin
            r_cnt <= '0;
            r_stb <= 1'b0;
         end else if (r_in_s2[i] != r_stb) begin
            if (r_cnt == c_DEB_MAX) begin
               r_stb <= r_in_s2[i];
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end

      assign w_stable[i] = r_stb;
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_stable_d  <= '0;
         r_btn_rise  <= '0;
         r_sw_change <= 1'b0;
      end else begin
         r_stable_d  <= w_stable;
         r_btn_rise  <= w_stable[NUM_BTN-1:0] & ~r_stable_d[NUM_BTN-1:0];
         r_sw_change <= |(w_stable[c_NCH-1:NUM_BTN] ^ r_stable_d[c_NCH-1:NUM_BTN]);
      end
   end

   // Pulses are masked while the SoC is held in reset so no stale IRQ leaks out.
   assign soc_rst_o   = r_soc_rst;
   assign btn_o       = w_stable[NUM_BTN-1:0];
   assign sw_o        = w_stable[c_NCH-1:NUM_BTN];
   assign btn_rise_o  = r_btn_rise & {NUM_BTN{~r_soc_rst}};
   assign sw_change_o = r_sw_change & ~r_soc_rst;

endmodule

`default_nettype wire

// File: tb/tb_board_io_cond.sv
// ============================================================================
// tb_board_io_cond: directed stimulus with a cycle-stamped expectation queue.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_board_io_cond;

    localparam int NB = 2;
    localparam int NS = 4;

    logic          clk    = 1'b0;
    logic          arst_n = 1'b0;
    logic          pll    = 1'b0;
    logic [NB-1:0] btn    = '0;
    logic [NS-1:0] sw     = '0;
    logic          soc_rst;
    logic [NB-1:0] btn_o;
    logic [NB-1:0] btn_rise;
    logic [NS-1:0] sw_o;
    logic          sw_chg;

    board_io_cond #(
        .NUM_BTN         (NB),
        .NUM_SW          (NS),
        .DEBOUNCE_CYCLES (4),
        .RST_HOLD_CYCLES (3)
    ) dut (
        .clk_i        (clk),
        .arst_n_i     (arst_n),
        .pll_locked_i (pll),
        .btn_i        (btn),
        .sw_i         (sw),
        .soc_rst_o    (soc_rst),
        .btn_o        (btn_o),
        .btn_rise_o   (btn_rise),
        .sw_o         (sw_o),
        .sw_change_o  (sw_chg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         cyc;
        string      nm;
        logic [9:0] mask;
        logic [9:0] val;
    } exp_t;

    exp_t q[$];

    // Observed vector: {soc_rst, btn_o[1:0], btn_rise[1:0], sw_o[3:0], sw_chg}
    localparam logic [9:0] M_RST  = 10'b1000000000;
    localparam logic [9:0] M_BTN  = 10'b0110000000;
    localparam logic [9:0] M_RISE = 10'b0001100000;
    localparam logic [9:0] M_SW   = 10'b0000011110;
    localparam logic [9:0] M_CHG  = 10'b0000000001;
    localparam logic [9:0] M_ALL  = 10'b1111111111;

    task automatic expect_at(input int c, input string nm, input logic [9:0] m, input logic [9:0] v);
        exp_t x;
        x.cyc  = c;
        x.nm   = nm;
        x.mask = m;
        x.val  = v;
        q.push_back(x);
    endtask

    task automatic ex_rst(input int c, input logic v);
        expect_at(c, "soc_rst", M_RST, {v, 9'b0});
    endtask
    task automatic ex_btn(input int c, input logic [1:0] v);
        expect_at(c, "btn_o", M_BTN, {1'b0, v, 7'b0});
    endtask
    task automatic ex_rise(input int c, input logic [1:0] v);
        expect_at(c, "btn_rise", M_RISE, {3'b0, v, 5'b0});
    endtask
    task automatic ex_sw(input int c, input logic [3:0] v);
        expect_at(c, "sw_o", M_SW, {5'b0, v, 1'b0});
    endtask
    task automatic ex_chg(input int c, input logic v);
        expect_at(c, "sw_change", M_CHG, {9'b0, v});
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [9:0] obs;

    always @(negedge clk) begin
        obs = {soc_rst, btn_o, btn_rise, sw_o, sw_chg};
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc <= cyc) begin
                total++;
                if (q[i].cyc < cyc || (obs & q[i].mask) !== (q[i].val & q[i].mask)) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%b want=%b mask=%b",
                             q[i].nm, q[i].cyc, obs & q[i].mask, q[i].val & q[i].mask, q[i].mask);
                end
                q.delete(i);
            end
        end
    end

    initial begin
        int e;
        int f;
        logic [4:0] pat;

        // Reset state, then PLL-gated reset sequence
        adv(3);
        total++;
        if ({soc_rst, btn_o, btn_rise, sw_o, sw_chg} !== 10'b1000000000) begin
            bad++;
            $display("FAIL direct reset_state got=%b", {soc_rst, btn_o, btn_rise, sw_o, sw_chg});
        end
        e = cyc;
        expect_at(e, "reset_state", M_ALL, 10'b1000000000);
        arst_n = 1'b1;
        adv(10);
        e = cyc;
        ex_rst(e, 1'b1);
        pll = 1'b1;
        for (int d = 1; d <= 5; d++) ex_rst(e + d, 1'b1);
        ex_rst(e + 6, 1'b0);
        adv(8);
        total++;
        if (soc_rst !== 1'b0) begin
            bad++;
            $display("FAIL direct soc_rst release got=%b", soc_rst);
        end

        // Three-cycle glitch is rejected
        e = cyc;
        btn = 2'b01;
        for (int d = 1; d <= 10; d++) begin
            ex_btn(e + d, 2'b00);
            ex_rise(e + d, 2'b00);
        end
        adv(3);
        btn = 2'b00;
        adv(9);

        // Ten-cycle pulse is accepted, falling edge gives no pulse
        e = cyc;
        btn = 2'b01;
        ex_btn(e + 5, 2'b00);
        ex_btn(e + 6, 2'b01);
        ex_rise(e + 6, 2'b00);
        ex_rise(e + 7, 2'b01);
        ex_rise(e + 8, 2'b00);
        adv(10);
        btn = 2'b00;
        ex_btn(e + 15, 2'b01);
        ex_btn(e + 16, 2'b00);
        for (int d = 15; d <= 18; d++) ex_rise(e + d, 2'b00);
        adv(10);

        // Bounce on btn[1]: 1,0,1,1,0 then steady 1
        e = cyc;
        pat = 5'b01101;
        for (int d = 1; d <= 10; d++) ex_btn(e + d, 2'b00);
        for (int d = 1; d <= 11; d++) ex_rise(e + d, 2'b00);
        ex_btn(e + 11, 2'b10);
        ex_rise(e + 12, 2'b10);
        ex_rise(e + 13, 2'b00);
        for (int j = 0; j < 5; j++) begin
            btn[1] = pat[j];
            adv(1);
        end
        btn[1] = 1'b1;
        adv(9);
        btn[1] = 1'b0;
        adv(8);

        // Switch group with a single change pulse per update
        e = cyc;
        sw = 4'b1010;
        ex_sw(e + 5, 4'b0000);
        ex_sw(e + 6, 4'b1010);
        ex_chg(e + 6, 1'b0);
        ex_chg(e + 7, 1'b1);
        ex_chg(e + 8, 1'b0);
        adv(10);
        sw = 4'b1011;
        ex_sw(e + 15, 4'b1010);
        ex_sw(e + 16, 4'b1011);
        ex_chg(e + 16, 1'b0);
        ex_chg(e + 17, 1'b1);
        ex_chg(e + 18, 1'b0);
        adv(10);
        total++;
        if (sw_o !== 4'b1011) begin
            bad++;
            $display("FAIL direct sw_o got=%b want=1011", sw_o);
        end

        // One-cycle PLL loss while running
        e = cyc;
        pll = 1'b0;
        ex_rst(e + 2, 1'b0);
        for (int d = 3; d <= 6; d++) ex_rst(e + d, 1'b1);
        ex_rst(e + 7, 1'b0);
        adv(1);
        pll = 1'b1;
        adv(9);

        // Async reset mid-debounce, then a button held across reset release
        e = cyc;
        btn = 2'b01;
        adv(3);
        arst_n = 1'b0;
        pll    = 1'b0;
        expect_at(e + 3, "async_clear", M_ALL, 10'b1000000000);
        #1;
        total++;
        if (soc_rst !== 1'b1 || btn_o !== 2'b00) begin
            bad++;
            $display("FAIL direct async_clear soc_rst=%b btn_o=%b", soc_rst, btn_o);
        end
        adv(2);
        arst_n = 1'b1;
        f = cyc;
        ex_btn(f + 5, 2'b00);
        ex_btn(f + 6, 2'b01);
        ex_sw(f + 6, 4'b1011);
        for (int d = 6; d <= 8; d++) begin
            ex_rise(f + d, 2'b00);
            ex_chg(f + d, 1'b0);
        end
        ex_rst(f + 8, 1'b1);
        adv(9);
        pll = 1'b1;
        ex_rst(f + 14, 1'b1);
        ex_rst(f + 15, 1'b0);
        for (int d = 15; d <= 18; d++) begin
            ex_rise(f + d, 2'b00);
            ex_chg(f + d, 1'b0);
            ex_btn(f + d, 2'b01);
        end
        adv(12);
        total++;
        if (soc_rst !== 1'b0 || btn_o !== 2'b01) begin
            bad++;
            $display("FAIL direct final soc_rst=%b btn_o=%b", soc_rst, btn_o);
        end

        while (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL %s cyc=%0d never checked (timeout)", q[0].nm, q[0].cyc);
            void'(q.pop_front());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
